// File: rtl/uart_demux_pkg.sv
// rtl/uart_demux_pkg.sv - shared link tags and match-control field positions
package uart_demux_pkg;

  localparam logic [3:0] TAG_PL1_POSX  = 4'd3;
  localparam logic [3:0] TAG_PL1_POSY  = 4'd4;
  localparam logic [3:0] TAG_BALL_POSX = 4'd5;
  localparam logic [3:0] TAG_BALL_POSY = 4'd6;
  localparam logic [3:0] TAG_CTRL      = 4'd7;

  localparam int CTRL_PL1_SCORE_LSB  = 0;
  localparam int CTRL_PL2_SCORE_LSB  = 4;
  localparam int CTRL_FLAG_POINT_BIT = 8;
  localparam int CTRL_END_GAME_BIT   = 9;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } demux_state_t;

  function automatic logic [3:0] word_tag(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/uart_demux_link_watchdog.sv
// rtl/uart_demux_link_watchdog.sv - link-loss watchdog, alive until TIMEOUT_CYCLES-1 cycles pass without a kick
module link_watchdog #(
  parameter int TIMEOUT_CYCLES = 6500000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic alive
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // alive falls on the same edge the counter lands on LAST; a kick always wins
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      alive <= 1'b0;
    end else if (kick) begin
      cnt   <= '0;
      alive <= 1'b1;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST - 1'b1) alive <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_demux.sv
// rtl/uart_demux.sv - tagged-word frame collector committing game state atomically
// Optional link watchdog: BLOBBY_LINK_WATCHDOG_EN
module uart_demux
  import uart_demux_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 6500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic [11:0] pl1_posx,
  output logic [11:0] pl1_posy,
  output logic [11:0] ball_posx,
  output logic [11:0] ball_posy,
  output logic [3:0]  pl1_score,
  output logic [3:0]  pl2_score,
  output logic        flag_point,
  output logic        end_game,
  output logic        frame_update,
  output logic        link_ok,
  output logic [7:0]  err_cnt
);

  logic [3:0]   tag;
  logic [11:0]  payload;
  demux_state_t state, state_nxt;
  logic [2:0]   exp_tag, exp_tag_nxt;
  logic         store, abort, commit;
  logic [11:0]  sh_pl1_posx, sh_pl1_posy, sh_ball_posx, sh_ball_posy;

  assign tag     = word_tag(data_in);
  assign payload = data_in[11:0];

  always_comb begin
    state_nxt   = state;
    exp_tag_nxt = exp_tag;
    store       = 1'b0;
    abort       = 1'b0;
    commit      = 1'b0;
    if (data_valid) begin
      case (state)
        ST_IDLE: begin
          if (tag == TAG_PL1_POSX) begin
            state_nxt   = ST_COLLECT;
            exp_tag_nxt = TAG_PL1_POSY[2:0];
            store       = 1'b1;
          end
        end
        ST_COLLECT: begin
          if (tag == {1'b0, exp_tag}) begin
            store = 1'b1;
            if (tag == TAG_CTRL) begin
              commit    = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              exp_tag_nxt = exp_tag + 3'd1;
            end
          end else begin
            // an out-of-order tag 3 is treated as the start of a fresh frame
            abort = 1'b1;
            if (tag == TAG_PL1_POSX) begin
              store       = 1'b1;
              exp_tag_nxt = TAG_PL1_POSY[2:0];
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      exp_tag      <= TAG_PL1_POSX[2:0];
      sh_pl1_posx  <= '0;
      sh_pl1_posy  <= '0;
      sh_ball_posx <= '0;
      sh_ball_posy <= '0;
    end else begin
      state   <= state_nxt;
      exp_tag <= exp_tag_nxt;
      if (abort) begin
        sh_pl1_posx  <= '0;
        sh_pl1_posy  <= '0;
        sh_ball_posx <= '0;
        sh_ball_posy <= '0;
      end
      if (store) begin
        case (tag)
          TAG_PL1_POSX:  sh_pl1_posx  <= payload;
          TAG_PL1_POSY:  sh_pl1_posy  <= payload;
          TAG_BALL_POSX: sh_ball_posx <= payload;
          TAG_BALL_POSY: sh_ball_posy <= payload;
          default: ;
        endcase
      end
    end
  end

  // control word is committed straight from data_in, so it needs no shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      pl1_posx     <= '0;
      pl1_posy     <= '0;
      ball_posx    <= '0;
      ball_posy    <= '0;
      pl1_score    <= '0;
      pl2_score    <= '0;
      flag_point   <= 1'b0;
      end_game     <= 1'b0;
      frame_update <= 1'b0;
      err_cnt      <= '0;
    end else begin
      frame_update <= commit;
      if (commit) begin
        pl1_posx   <= sh_pl1_posx;
        pl1_posy   <= sh_pl1_posy;
        ball_posx  <= sh_ball_posx;
        ball_posy  <= sh_ball_posy;
        pl1_score  <= payload[CTRL_PL1_SCORE_LSB +: 4];
        pl2_score  <= payload[CTRL_PL2_SCORE_LSB +: 4];
        flag_point <= payload[CTRL_FLAG_POINT_BIT];
        end_game   <= payload[CTRL_END_GAME_BIT];
      end
      if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef BLOBBY_LINK_WATCHDOG_EN
  link_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_link_watchdog (
    .clk  (clk),
    .rst  (rst),
    .kick (commit),
    .alive(link_ok)
  );
`else
  always_ff @(posedge clk) begin
    if (rst) link_ok <= 1'b0;
    else if (commit) link_ok <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_demux.sv
// tb/tb_uart_demux.sv - self-checking bench for uart_demux
module tb_uart_demux;

  localparam int TO = 100;
`ifdef BLOBBY_LINK_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, data_valid;
  logic [15:0] data_in;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game, frame_update, link_ok;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  uart_demux #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy), .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score), .flag_point(flag_point), .end_game(end_game),
    .frame_update(frame_update), .link_ok(link_ok), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model: frame progress as "words collected so far"
  logic [11:0] m_pl1x, m_pl1y, m_bx, m_by;
  logic [3:0]  m_s1, m_s2;
  logic        m_fp, m_eg, m_fu, m_lok;
  int          m_err, m_n, m_since;
  bit          m_seen;
  logic [11:0] m_frame [5];

  function automatic void model_reset();
    m_pl1x = 0; m_pl1y = 0; m_bx = 0; m_by = 0; m_s1 = 0; m_s2 = 0;
    m_fp = 0; m_eg = 0; m_fu = 0; m_lok = 0;
    m_err = 0; m_n = 0; m_since = 0; m_seen = 0;
    for (int i = 0; i < 5; i++) m_frame[i] = 0;
  endfunction

  function automatic void model_edge(bit v, logic [15:0] w);
    int t;
    bit c;
    t = int'(w[15:12]);
    c = 0;
    if (v) begin
      if (m_n == 0) begin
        if (t == 3) begin m_frame[0] = w[11:0]; m_n = 1; end
      end else if (t == 3 + m_n) begin
        m_frame[m_n] = w[11:0];
        m_n++;
        if (m_n == 5) begin c = 1; m_n = 0; end
      end else begin
        if (m_err < 255) m_err++;
        if (t == 3) begin m_frame[0] = w[11:0]; m_n = 1; end
        else m_n = 0;
      end
    end
    m_fu = c;
    if (c) begin
      m_pl1x = m_frame[0]; m_pl1y = m_frame[1]; m_bx = m_frame[2]; m_by = m_frame[3];
      m_s1 = m_frame[4][3:0]; m_s2 = m_frame[4][7:4];
      m_fp = m_frame[4][8]; m_eg = m_frame[4][9];
      m_seen = 1; m_since = 0;
    end else if (m_since < 1000000) begin
      m_since++;
    end
    m_lok = WD_EN ? (m_seen && m_since <= TO - 2) : m_seen;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("pl1_posx", 32'(pl1_posx), 32'(m_pl1x));
    chk("pl1_posy", 32'(pl1_posy), 32'(m_pl1y));
    chk("ball_posx", 32'(ball_posx), 32'(m_bx));
    chk("ball_posy", 32'(ball_posy), 32'(m_by));
    chk("pl1_score", 32'(pl1_score), 32'(m_s1));
    chk("pl2_score", 32'(pl2_score), 32'(m_s2));
    chk("flag_point", 32'(flag_point), 32'(m_fp));
    chk("end_game", 32'(end_game), 32'(m_eg));
    chk("frame_update", 32'(frame_update), 32'(m_fu));
    chk("link_ok", 32'(link_ok), 32'(m_lok));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  // drive at the falling edge, model the rising edge, check at the next falling edge
  task automatic cycle(input bit r, input bit v, input logic [15:0] w);
    rst = r; data_valid = v; data_in = w;
    @(posedge clk);
    if (r) model_reset();
    else model_edge(v, w);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit          v;
    logic [15:0] w;
    logic [11:0] pl1x, pl1y, bx, by;
    logic [3:0]  s1, s2;
    logic        fp, eg, fu, lok;
    logic [7:0]  err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit v, logic [15:0] w, logic [11:0] a, logic [11:0] b,
                              logic [11:0] c, logic [11:0] d, logic [3:0] s1, logic [3:0] s2,
                              logic fp, logic eg, logic fu, logic lok, logic [7:0] err);
    vec_t e;
    e.v = v; e.w = w; e.pl1x = a; e.pl1y = b; e.bx = c; e.by = d;
    e.s1 = s1; e.s2 = s2; e.fp = fp; e.eg = eg; e.fu = fu; e.lok = lok; e.err = err;
    tbl.push_back(e);
  endfunction

  initial begin
    int fall;
    int exp_t;
    logic [15:0] w;

    add(1, 16'h3123, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 16'h4045, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 16'h5200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 16'h6300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 16'h7253, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 1, 1, 0);
    add(0, 16'h0000, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 0);
    add(1, 16'h3111, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 0);
    add(1, 16'h4222, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 0);
    add(1, 16'h6333, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 1);
    add(1, 16'h4444, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 1);
    add(1, 16'h7FFF, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 1);
    add(1, 16'h3111, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 1);
    add(1, 16'h3AAA, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 2);
    add(1, 16'h4001, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 2);
    add(0, 16'h7123, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 2);
    add(1, 16'h5002, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 2);
    add(1, 16'h6003, 12'h123, 12'h045, 12'h200, 12'h300, 3, 5, 0, 1, 0, 1, 2);
    add(1, 16'h7000, 12'hAAA, 12'h001, 12'h002, 12'h003, 0, 0, 0, 0, 1, 1, 2);
    add(1, 16'h3555, 12'hAAA, 12'h001, 12'h002, 12'h003, 0, 0, 0, 0, 0, 1, 2);
    add(1, 16'h0123, 12'hAAA, 12'h001, 12'h002, 12'h003, 0, 0, 0, 0, 0, 1, 3);
    add(1, 16'h3001, 12'hAAA, 12'h001, 12'h002, 12'h003, 0, 0, 0, 0, 0, 1, 3);
    add(1, 16'h4002, 12'hAAA, 12'h001, 12'h002, 12'h003, 0, 0, 0, 0, 0, 1, 3);
    add(1, 16'h5003, 12'hAAA, 12'h001, 12'h002, 12'h003, 0, 0, 0, 0, 0, 1, 3);
    add(1, 16'h6004, 12'hAAA, 12'h001, 12'h002, 12'h003, 0, 0, 0, 0, 0, 1, 3);
    add(1, 16'h7F9A, 12'h001, 12'h002, 12'h003, 12'h004, 4'hA, 4'h9, 1, 1, 1, 1, 3);

    rst = 1'b1; data_valid = 1'b0; data_in = '0;
    model_reset();
    @(negedge clk);
    cycle(1, 0, 16'h0);
    cycle(1, 1, 16'h3123);

    foreach (tbl[i]) begin
      cycle(0, tbl[i].v, tbl[i].w);
      chk($sformatf("vec%0d pl1_posx", i), 32'(pl1_posx), 32'(tbl[i].pl1x));
      chk($sformatf("vec%0d pl1_posy", i), 32'(pl1_posy), 32'(tbl[i].pl1y));
      chk($sformatf("vec%0d ball_posx", i), 32'(ball_posx), 32'(tbl[i].bx));
      chk($sformatf("vec%0d ball_posy", i), 32'(ball_posy), 32'(tbl[i].by));
      chk($sformatf("vec%0d scores", i), 32'({pl2_score, pl1_score}), 32'({tbl[i].s2, tbl[i].s1}));
      chk($sformatf("vec%0d flags", i), 32'({end_game, flag_point}), 32'({tbl[i].eg, tbl[i].fp}));
      chk($sformatf("vec%0d frame_update", i), 32'(frame_update), 32'(tbl[i].fu));
      chk($sformatf("vec%0d link_ok", i), 32'(link_ok), 32'(tbl[i].lok));
      chk($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(tbl[i].err));
    end

    // reset in the middle of a frame
    cycle(0, 1, 16'h3111);
    cycle(0, 1, 16'h4222);
    cycle(1, 0, 16'h0);
    chk("midrst pl1_posx", 32'(pl1_posx), 32'h0);
    chk("midrst err_cnt", 32'(err_cnt), 32'h0);
    chk("midrst link_ok", 32'(link_ok), 32'h0);
    cycle(0, 1, 16'h3321); cycle(0, 1, 16'h4654); cycle(0, 1, 16'h5987);
    cycle(0, 1, 16'h6CBA); cycle(0, 1, 16'h7312);
    chk("postrst frame_update", 32'(frame_update), 32'h1);
    chk("postrst pl1_posx", 32'(pl1_posx), 32'h321);
    chk("postrst ball_posy", 32'(ball_posy), 32'hCBA);
    chk("postrst link_ok", 32'(link_ok), 32'h1);

    // silence after a commit: watchdog fall position
    fall = -1;
    for (int i = 1; i <= 150; i++) begin
      cycle(0, 0, 16'h0);
      if (link_ok === 1'b0 && fall < 0) fall = i;
    end
    chk("timeout cycle", 32'(fall), WD_EN ? 32'd99 : 32'hFFFF_FFFF);
    chk("timeout pl1_posx hold", 32'(pl1_posx), 32'h321);
    cycle(0, 1, 16'h3001); cycle(0, 1, 16'h4002); cycle(0, 1, 16'h5003);
    cycle(0, 1, 16'h6004); cycle(0, 1, 16'h7005);
    chk("relink frame_update", 32'(frame_update), 32'h1);
    chk("relink link_ok", 32'(link_ok), 32'h1);

    // commit lands on the very edge the watchdog would expire
    for (int i = 0; i < 94; i++) cycle(0, 0, 16'h0);
    cycle(0, 1, 16'h3011); cycle(0, 1, 16'h4022); cycle(0, 1, 16'h5033);
    cycle(0, 1, 16'h6044); cycle(0, 1, 16'h7055);
    chk("race link_ok", 32'(link_ok), 32'h1);
    chk("race frame_update", 32'(frame_update), 32'h1);

    // err_cnt saturation
    for (int i = 0; i < 300; i++) begin
      cycle(0, 1, 16'h3000);
      cycle(0, 1, 16'h0000);
    end
    chk("saturate err_cnt", 32'(err_cnt), 32'd255);
    cycle(0, 1, 16'h3000);
    cycle(0, 1, 16'h9000);
    chk("saturate hold err_cnt", 32'(err_cnt), 32'd255);

    cycle(1, 0, 16'h0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int k = 0; k < 110; k++) cycle(0, 0, 16'($urandom));
      end
      exp_t = (m_n == 0) ? 3 : 3 + m_n;
      w = 16'($urandom);
      if ($urandom_range(0, 9) < 7) w[15:12] = 4'(exp_t);
      cycle($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_demux.md
UART_DEMUX -- requirements
Module: uart_demux

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 6500000, link-loss timeout in clk cycles.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data_in  input  16  received word {tag[15:12], payload[11:0]} from the 8-to-16 converter.
REQ-005 SHALL have port data_valid  input  1  one-cycle strobe; data_in is valid only in that cycle.
REQ-006 SHALL have port pl1_posx  output  12  committed player-1 x position.
REQ-007 SHALL have port pl1_posy  output  12  committed player-1 y position.
REQ-008 SHALL have port ball_posx  output  12  committed ball x position.
REQ-009 SHALL have port ball_posy  output  12  committed ball y position.
REQ-010 SHALL have port pl1_score  output  4  committed score, payload[3:0] of tag 7.
REQ-011 SHALL have port pl2_score  output  4  committed score, payload[7:4] of tag 7.
REQ-012 SHALL have port flag_point  output  1  committed payload[8] of tag 7.
REQ-013 SHALL have port end_game  output  1  committed payload[9] of tag 7.
REQ-014 SHALL have port frame_update  output  1  one-cycle pulse when a complete frame is committed.
REQ-015 SHALL have port link_ok  output  1  high while valid frames arrive within TIMEOUT_CYCLES.
REQ-016 SHALL have port err_cnt  output  8  count of aborted frames, saturating at 255.

Function
REQ-017 SHALL recognise data tags 3 (pl1_posx), 4 (pl1_posy), 5 (ball_posx), 6 (ball_posy), 7 (match control); tags 0-2 and 8-15 SHALL be filler.
REQ-018 SHALL implement FSM states IDLE and COLLECT with a 3-bit expected-tag register.
REQ-019 IDLE: data_valid with tag 3 SHALL store payload in shadow register, go COLLECT, expect 4; all other words ignored.
REQ-020 COLLECT: data_valid with tag equal to expected tag SHALL store payload in the matching shadow register and increment expected tag.
REQ-021 COLLECT: accepted tag 7 SHALL copy all shadow registers to outputs on the next clk edge, pulse frame_update for exactly one cycle, return to IDLE.
REQ-022 COLLECT: any other tag, filler included, SHALL abort the frame, increment err_cnt (saturating), discard shadows; if that tag is 3 it SHALL restart collection (COLLECT, expect 4), else go IDLE.
REQ-023 Outputs SHALL change only at commit; partial frames SHALL never be visible.
REQ-024 Cycles without data_valid SHALL not change state.
REQ-025 Latency from tag-7 data_valid to updated outputs and frame_update SHALL be 1 cycle.
REQ-026 Payload bits [11:10] of tag 7 SHALL be ignored.
REQ-027 Watchdog counter SHALL reload to 0 on each commit and increment otherwise; when it reaches TIMEOUT_CYCLES-1, link_ok SHALL drop to 0 and the counter SHALL hold.
REQ-028 Commit SHALL set link_ok to 1; commit in the same cycle as timeout SHALL win.
REQ-029 link_ok SHALL never drop without a timeout; committed position/score outputs SHALL hold last values when link_ok is 0.

Reset
REQ-030 rst SHALL set all data outputs, frame_update, link_ok, err_cnt, shadows and watchdog to 0, FSM to IDLE.
REQ-031 rst mid-frame SHALL discard the partial frame without incrementing err_cnt.

Configuration
REQ-032 Macro BLOBBY_LINK_WATCHDOG_EN defined: watchdog per REQ-027..REQ-028 compiled in.
REQ-033 Macro absent: no watchdog counter; link_ok SHALL go to 1 at the first commit and stay 1 until rst.

Structure
REQ-034 Tag constants (3..7) and the tag-7 bit-field positions SHALL reside in a shared package used by this block and the transmitter-side selector.
REQ-035 Watchdog SHALL be a sub-module named link_watchdog (inputs clk, rst, kick; output alive), instantiated only under BLOBBY_LINK_WATCHDOG_EN.

Verification
REQ-036 Words 0x3123,0x4045,0x5200,0x6300,0x7253 -> next cycle pl1_posx=0x123, pl1_posy=0x045, ball_posx=0x200, ball_posy=0x300, pl1_score=3, pl2_score=5, flag_point=0, end_game=1, frame_update one pulse, link_ok=1.
REQ-037 Words 0x3111,0x4222,0x6333 -> err_cnt=1, outputs unchanged, FSM IDLE.
REQ-038 Words 0x3111,0x3AAA,0x4001,0x5002,0x6003,0x7000 -> err_cnt=1, commit with pl1_posx=0xAAA.
REQ-039 300 aborted frames -> err_cnt=255.
REQ-040 TIMEOUT_CYCLES=100, one frame then silence -> link_ok falls exactly 99 cycles after the frame_update pulse; next valid frame -> link_ok=1 with frame_update.
REQ-041 rst asserted after 0x3111,0x4222 -> all outputs 0, err_cnt 0; following full frame commits normally.
